sequencer_monitor: RTL and testbench
====================================

// Module: sequencer_monitor
// PURPOSE
//  Passive receive-side checker for the 5-state sequencer output bus {terminal,out1,out2,even,odd}.
//  Samples the 9-bit word every clock and decodes it back to a state index.
//  Locks onto the stream, checks every step against the legal transition table, and counts errors and laps.
//  Sits beside the sequencer in test/diagnostic builds; drives status only, never feeds back.
// PARAMETERS
//  LOCK_LEN  2  consecutive valid words needed to go UNLOCKED->LOCKED (range 1..15)
//  ERR_W     8  width of err_count, saturating
//  LAP_W     8  width of lap_count, wraps modulo 2^LAP_W
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high; clears all state and outputs
//  terminal     in   1      observed terminal bit
//  out1         in   3      observed out1
//  out2         in   3      observed out2
//  even         in   1      observed even bit
//  odd          in   1      observed odd bit
//  state_idx    out  3      decoded state of last sampled word: 0=none/invalid, 1..5=S1..S5
//  locked       out  1      monitor is in LOCKED
//  illegal_word out  1      1-cycle pulse: non-codeword seen while LOCKED
//  illegal_step out  1      1-cycle pulse: valid word but illegal transition while LOCKED
//  err_count    out  ERR_W  illegal_word + illegal_step events, saturates at all-ones
//  lap_count    out  LAP_W  entries into S5 while LOCKED
// BEHAVIOUR
//  - One clock: clk. Reset is asynchronous and active-high (port reset); every output resets to 0 and the FSM to UNLOCKED.
//  - Word W = {terminal,out1,out2,even,odd}, 9 bits. Codewords: S1=9'h069, S2=9'h0B2, S3=9'h05D, S4=9'h0CE, S5=9'h1A9.
//  - Any other value is invalid, including even==odd and terminal=1 with a non-S5 body.
//  - Legal steps (prev->cur): S1->{S1,S2}; S2->{S2,S3}; S3->{S3,S4}; S4->{S4,S5}; S5->{S5,S3}.
//  - Any state ->S1 is always legal (restart or sequencer reset).
//  - Latency: all outputs are registered, one cycle after W is sampled. Flags and counters update on the same edge.
//  - FSM UNLOCKED:
//    - A valid W increments match_cnt; a valid W after an illegal step restarts match_cnt at 1.
//    - An invalid W clears match_cnt.
//    - When match_cnt reaches LOCK_LEN, go to LOCKED. No flags or counters change while UNLOCKED.
//  - FSM LOCKED:
//    - Invalid W: pulse illegal_word, err_count+1, go to UNLOCKED, clear match_cnt, state_idx=0.
//    - Valid W with illegal step: pulse illegal_step, err_count+1, stay LOCKED, prev<=cur.
//    - Valid W with legal step: prev<=cur. If prev!=S5 and cur==S5, lap_count+1.
//  - prev is updated on every valid W in both FSM states. state_idx always reflects the last W.
//  - err_count holds at 2^ERR_W-1. lap_count wraps to 0.
//  - illegal_word and illegal_step are never asserted in the same cycle.
//  - Reset asserted mid-stream clears immediately. After release, re-locking needs LOCK_LEN fresh valid words.
// STRUCTURE
//  - Package seq_mon_pkg holds:
//    - typedef enum logic[2:0] seq_idx_t {IDX_NONE,IDX_S1..IDX_S5}
//    - localparam codewords CW_S1..CW_S5
//    - function legal_step(prev,cur)
//  - Sub-module seq_word_decoder: purely combinational, 9-bit W -> seq_idx_t.
//  - Top level: lock FSM, prev register, counters and output registers.
// TESTING
//  1. Reset, then S1,S1,S2 (LOCK_LEN=2) -> locked=1 at cycle 3. state_idx sequence 1,1,2. No flags.
//  2. Locked walk S1,S2,S3,S4,S5,S3,S4,S5 -> lap_count=2, err_count=0, no flags.
//  3. Locked, S2 then S4 -> illegal_step pulses for 1 cycle, err_count=1, locked stays 1, state_idx=4.
//  4. Locked, W=9'h0B3 (even==odd) -> illegal_word pulses, err_count+1, locked=0, state_idx=0. Then S1,S2 -> relock.
//  5. Force 300 illegal steps with ERR_W=8 -> err_count holds 255. Force 257 laps with LAP_W=8 -> lap_count=1.
//  6. Assert reset mid-walk, asynchronously between edges -> all outputs 0 immediately. After release, 1 valid word leaves locked=0.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// Shared types, codewords and transition rules for the sequencer output monitor.
package seq_mon_pkg;

    typedef enum logic [2:0] {
        IDX_NONE = 3'd0,
        IDX_S1   = 3'd1,
        IDX_S2   = 3'd2,
        IDX_S3   = 3'd3,
        IDX_S4   = 3'd4,
        IDX_S5   = 3'd5
    } seq_idx_t;

    // Word layout: {terminal, out1[2:0], out2[2:0], even, odd}
    localparam logic [8:0] CW_S1 = 9'h069;
    localparam logic [8:0] CW_S2 = 9'h0B2;
    localparam logic [8:0] CW_S3 = 9'h05D;
    localparam logic [8:0] CW_S4 = 9'h0CE;
    localparam logic [8:0] CW_S5 = 9'h1A9;

    // With no history (prev == IDX_NONE) any valid word is accepted as a legal start.
    function automatic logic legal_step(seq_idx_t prev, seq_idx_t cur);
        logic ok;
        ok = 1'b0;
        if (cur == IDX_S1 || prev == IDX_NONE || cur == prev) begin
            ok = 1'b1;
        end else begin
            case (prev)
                IDX_S1:  ok = (cur == IDX_S2);
                IDX_S2:  ok = (cur == IDX_S3);
                IDX_S3:  ok = (cur == IDX_S4);
                IDX_S4:  ok = (cur == IDX_S5);
                IDX_S5:  ok = (cur == IDX_S3);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_word_decoder.sv
// Combinational decode of a 9-bit sequencer output word into a state index.
module seq_word_decoder
    import seq_mon_pkg::*;
(
    input  logic [8:0] word_i,
    output seq_idx_t   idx_o
);

    always_comb begin
        idx_o = IDX_NONE;
        case (word_i)
            CW_S1:   idx_o = IDX_S1;
            CW_S2:   idx_o = IDX_S2;
            CW_S3:   idx_o = IDX_S3;
            CW_S4:   idx_o = IDX_S4;
            CW_S5:   idx_o = IDX_S5;
            default: idx_o = IDX_NONE;
        endcase
    end

endmodule

// File: rtl/sequencer_monitor.sv
// Passive checker: locks onto the sequencer output stream, flags bad words and
// illegal transitions, and counts errors and laps through S5.
module sequencer_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned LOCK_LEN = 2,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned LAP_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             terminal,
    input  logic [2:0]       out1,
    input  logic [2:0]       out2,
    input  logic             even,
    input  logic             odd,
    output logic [2:0]       state_idx,
    output logic             locked,
    output logic             illegal_word,
    output logic             illegal_step,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count
);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

    localparam logic [3:0] LockLen = 4'(LOCK_LEN);

    lock_state_e      state_q, state_d;
    seq_idx_t         prev_q, prev_d;
    seq_idx_t         cur_idx;
    logic [3:0]       match_q, match_d;
    logic [2:0]       idx_q, idx_d;
    logic             iw_q, iw_d;
    logic             is_q, is_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             valid;
    logic             step_ok;
    logic             err_inc;

    seq_word_decoder u_decoder (
        .word_i ({terminal, out1, out2, even, odd}),
        .idx_o  (cur_idx)
    );

    assign valid   = (cur_idx != IDX_NONE);
    assign step_ok = legal_step(prev_q, cur_idx);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        match_d = match_q;
        idx_d   = cur_idx;
        iw_d    = 1'b0;
        is_d    = 1'b0;
        lap_d   = lap_q;
        err_inc = 1'b0;

        case (state_q)
            StUnlocked: begin
                if (!valid) begin
                    match_d = 4'd0;
                end else begin
                    prev_d = cur_idx;
                    if (!step_ok) begin
                        match_d = 4'd1;
                    end else if (match_q < LockLen) begin
                        match_d = match_q + 4'd1;
                    end
                    if (match_d >= LockLen) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (!valid) begin
                    iw_d    = 1'b1;
                    err_inc = 1'b1;
                    match_d = 4'd0;
                    state_d = StUnlocked;
                end else begin
                    prev_d = cur_idx;
                    if (!step_ok) begin
                        is_d    = 1'b1;
                        err_inc = 1'b1;
                    end else if (prev_q != IDX_S5 && cur_idx == IDX_S5) begin
                        lap_d = lap_q + LAP_W'(1);
                    end
                end
            end
            default: state_d = StUnlocked;
        endcase

        err_d = err_q;
        if (err_inc && !(&err_q)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StUnlocked;
            prev_q  <= IDX_NONE;
            match_q <= 4'd0;
            idx_q   <= 3'd0;
            iw_q    <= 1'b0;
            is_q    <= 1'b0;
            err_q   <= '0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            iw_q    <= iw_d;
            is_q    <= is_d;
            err_q   <= err_d;
            lap_q   <= lap_d;
        end
    end

    assign state_idx    = idx_q;
    assign locked       = (state_q == StLocked);
    assign illegal_word = iw_q;
    assign illegal_step = is_q;
    assign err_count    = err_q;
    assign lap_count    = lap_q;

endmodule

// File: tb/tb_sequencer_monitor.sv
// Directed and randomized check of sequencer_monitor against a behavioural model.
module tb_sequencer_monitor;

    localparam int LOCK_LEN = 2;
    localparam int ERR_W    = 8;
    localparam int LAP_W    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] w = 9'h000;

    logic             terminal, even, odd;
    logic [2:0]       out1, out2, state_idx;
    logic             locked, illegal_word, illegal_step;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;

    assign {terminal, out1, out2, even, odd} = w;

    sequencer_monitor #(
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W),
        .LAP_W    (LAP_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .terminal     (terminal),
        .out1         (out1),
        .out2         (out2),
        .even         (even),
        .odd          (odd),
        .state_idx    (state_idx),
        .locked       (locked),
        .illegal_word (illegal_word),
        .illegal_step (illegal_step),
        .err_count    (err_count),
        .lap_count    (lap_count)
    );

    always #5 clk = ~clk;

    logic [8:0] cw [1:5] = '{9'h069, 9'h0B2, 9'h05D, 9'h0CE, 9'h1A9};
    int nxt [1:5] = '{2, 3, 4, 5, 3};

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_locked, m_match, m_prev, m_idx, m_iw, m_is, m_err, m_lap;

    function automatic int dec(logic [8:0] x);
        for (int i = 1; i <= 5; i++) if (x == cw[i]) return i;
        return 0;
    endfunction

    function automatic bit legal(int p, int c);
        return (c == 1) || (p == 0) || (c == p) || (c == nxt[p]);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_match = 0; m_prev = 0; m_idx = 0;
        m_iw = 0; m_is = 0; m_err = 0; m_lap = 0;
    endtask

    task automatic model_word(input logic [8:0] x);
        int c;
        c = dec(x);
        m_idx = c; m_iw = 0; m_is = 0;
        if (m_locked == 0) begin
            if (c == 0) m_match = 0;
            else begin
                m_match = legal(m_prev, c) ? ((m_match < LOCK_LEN) ? m_match + 1 : m_match) : 1;
                m_prev = c;
                if (m_match >= LOCK_LEN) m_locked = 1;
            end
        end else if (c == 0) begin
            m_iw = 1; m_locked = 0; m_match = 0;
            if (m_err < (1 << ERR_W) - 1) m_err++;
        end else begin
            if (!legal(m_prev, c)) begin
                m_is = 1;
                if (m_err < (1 << ERR_W) - 1) m_err++;
            end else if (m_prev != 5 && c == 5) m_lap = (m_lap + 1) % (1 << LAP_W);
            m_prev = c;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("state_idx", 32'(state_idx), 32'(m_idx));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("illegal_word", 32'(illegal_word), 32'(m_iw));
        chk("illegal_step", 32'(illegal_step), 32'(m_is));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("lap_count", 32'(lap_count), 32'(m_lap));
    endtask

    task automatic step(input logic [8:0] word);
        w = word;
        @(posedge clk);
        #1;
        model_word(word);
        chk_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk_all();
        reset = 1'b0;
    endtask

    initial begin
        int r, c;
        model_reset();
        do_reset();

        // Lock-on: S1,S1,S2
        step(cw[1]); chk("t1_unlocked_after_1", 32'(locked), 32'd0);
        step(cw[1]); step(cw[2]);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_idx", 32'(state_idx), 32'd2);

        // Locked walk with two laps
        step(cw[1]); step(cw[2]); step(cw[3]); step(cw[4]);
        step(cw[5]); step(cw[3]); step(cw[4]); step(cw[5]);
        chk("t2_laps", 32'(lap_count), 32'd2);
        chk("t2_errs", 32'(err_count), 32'd0);

        // Illegal step S2->S4
        step(cw[1]); step(cw[2]); step(cw[4]);
        chk("t3_step_pulse", 32'(illegal_step), 32'd1);
        chk("t3_errs", 32'(err_count), 32'd1);
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_idx", 32'(state_idx), 32'd4);
        step(cw[4]);
        chk("t3_pulse_gone", 32'(illegal_step), 32'd0);

        // Invalid word with even==odd, then relock
        step(9'h0B3);
        chk("t4_word_pulse", 32'(illegal_word), 32'd1);
        chk("t4_errs", 32'(err_count), 32'd2);
        chk("t4_unlocked", 32'(locked), 32'd0);
        chk("t4_idx", 32'(state_idx), 32'd0);
        step(9'h169); // terminal set on S1 body
        chk("t4_terminal_invalid", 32'(state_idx), 32'd0);
        step(cw[1]); step(cw[2]);
        chk("t4_relock", 32'(locked), 32'd1);

        // Error counter saturation
        do_reset();
        step(cw[1]); step(cw[2]);
        for (int i = 0; i < 150; i++) begin
            step(cw[4]); step(cw[2]);
        end
        chk("t5_err_sat", 32'(err_count), 32'd255);

        // Lap counter wrap
        do_reset();
        step(cw[1]); step(cw[2]);
        for (int i = 0; i < 257; i++) begin
            step(cw[3]); step(cw[4]); step(cw[5]);
        end
        chk("t5_lap_wrap", 32'(lap_count), 32'd1);
        chk("t5_lap_errs", 32'(err_count), 32'd0);

        // Randomized mix of legal steps, arbitrary codewords and junk
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                c = $urandom_range(0, 2);
                if (m_prev == 0 || c == 0) c = 1;
                else if (c == 1) c = m_prev;
                else c = nxt[m_prev];
                step(cw[c]);
            end else if (r < 8) begin
                step(cw[$urandom_range(1, 5)]);
            end else begin
                step(9'($urandom_range(0, 511)));
            end
        end

        // Asynchronous reset between edges
        step(cw[1]); step(cw[2]); step(cw[3]); step(cw[4]); step(cw[5]);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        chk("t6_async_locked", 32'(locked), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(cw[1]);
        chk("t6_one_word_unlocked", 32'(locked), 32'd0);
        step(cw[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
